// File: rtl/ml_ahb_response_mux_master_0_if.sv
// Master-0 data-phase bus bundle: decoder select, slave responses and the muxed response to master 0.
// Error-capture signals exist only when ML_AHB_ERR_CAPTURE_EN is defined.
interface ml_ahb_response_mux_master_0_if #(
    parameter int NUM_SLAVES = 2,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_SLAVES-1:0]            hsel;
    logic                             hsel_default;
    logic [1:0]                       htrans;
    logic [31:0]                      haddr;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] hrdata_s;
    logic [NUM_SLAVES-1:0]            hreadyout_s;
    logic [NUM_SLAVES-1:0]            hresp_s;
    logic [DATA_WIDTH-1:0]            hrdata;
    logic                             hready;
    logic                             hresp;
`ifdef ML_AHB_ERR_CAPTURE_EN
    logic [31:0]                      err_addr;
    logic                             err_valid;
    logic                             err_clr;

    modport slave (
        input  hsel, hsel_default, htrans, haddr, hrdata_s, hreadyout_s, hresp_s, err_clr,
        output hrdata, hready, hresp, err_addr, err_valid
    );
    modport master (
        output hsel, hsel_default, htrans, haddr, hrdata_s, hreadyout_s, hresp_s, err_clr,
        input  hrdata, hready, hresp, err_addr, err_valid
    );
`else
    modport slave (
        input  hsel, hsel_default, htrans, haddr, hrdata_s, hreadyout_s, hresp_s,
        output hrdata, hready, hresp
    );
    modport master (
        output hsel, hsel_default, htrans, haddr, hrdata_s, hreadyout_s, hresp_s,
        input  hrdata, hready, hresp
    );
`endif
endinterface

// File: rtl/ml_ahb_response_mux_master_0.sv
// Master-0 AHB response mux with built-in two-cycle ERROR default slave.
// Optional first-error address capture is enabled by defining ML_AHB_ERR_CAPTURE_EN.
module ml_ahb_response_mux_master_0 #(
    parameter int NUM_SLAVES = 2,
    parameter int DATA_WIDTH = 32
) (
    input logic                          hclk,
    input logic                          hresetn,
    ml_ahb_response_mux_master_0_if.slave bus
);

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_e;

    ds_state_e              ds_state_r;
    ds_state_e              ds_state_s;
    logic [NUM_SLAVES-1:0]  dsel_r;
    logic                   dsel_def_r;
    logic                   accept_s;
    logic                   def_req_s;
    logic [DATA_WIDTH-1:0]  hrdata_mux_s;
    logic                   hready_mux_s;
    logic                   hresp_mux_s;

    function automatic logic [NUM_SLAVES-1:0] lowest_onehot(input logic [NUM_SLAVES-1:0] vec);
        logic [NUM_SLAVES-1:0] res;
        logic                  found;
        res   = {NUM_SLAVES{1'b0}};
        found = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (vec[i] && !found) begin
                res[i] = 1'b1;
                found  = 1'b1;
            end else begin
                res[i] = 1'b0;
            end
        end
        return res;
    endfunction

    // The muxed hready is also the slaves' HREADY, so it alone defines address-phase acceptance.
    assign accept_s  = hready_mux_s;
    assign def_req_s = bus.hsel_default & bus.htrans[1];

    // Data-phase select register, loaded only when the address phase is accepted.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            dsel_r     <= {NUM_SLAVES{1'b0}};
            dsel_def_r <= 1'b0;
        end else if (accept_s) begin
            dsel_r     <= lowest_onehot(bus.hsel);
            dsel_def_r <= def_req_s;
        end else begin
            dsel_r     <= dsel_r;
            dsel_def_r <= dsel_def_r;
        end
    end

    // Default-slave state register.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            ds_state_r <= DS_IDLE;
        end else begin
            ds_state_r <= ds_state_s;
        end
    end

    // Default-slave next state; ERR2 can chain straight into a new ERR1.
    always_comb begin
        ds_state_s = ds_state_r;
        case (ds_state_r)
            DS_IDLE: begin
                if (accept_s && def_req_s) begin
                    ds_state_s = DS_ERR1;
                end else begin
                    ds_state_s = DS_IDLE;
                end
            end
            DS_ERR1: ds_state_s = DS_ERR2;
            DS_ERR2: begin
                if (accept_s && def_req_s) begin
                    ds_state_s = DS_ERR1;
                end else begin
                    ds_state_s = DS_IDLE;
                end
            end
            default: ds_state_s = DS_IDLE;
        endcase
    end

    // Combinational return mux: default slave, one-hot real slave, or zero-wait OKAY.
    always_comb begin
        hrdata_mux_s = {DATA_WIDTH{1'b0}};
        hready_mux_s = 1'b1;
        hresp_mux_s  = 1'b0;
        if (dsel_def_r) begin
            case (ds_state_r)
                DS_ERR1: begin
                    hready_mux_s = 1'b0;
                    hresp_mux_s  = 1'b1;
                end
                DS_ERR2: begin
                    hready_mux_s = 1'b1;
                    hresp_mux_s  = 1'b1;
                end
                default: begin
                    hready_mux_s = 1'b1;
                    hresp_mux_s  = 1'b0;
                end
            endcase
        end else if (|dsel_r) begin
            hready_mux_s = |(dsel_r & bus.hreadyout_s);
            hresp_mux_s  = |(dsel_r & bus.hresp_s);
            for (int i = 0; i < NUM_SLAVES; i++) begin
                hrdata_mux_s = hrdata_mux_s
                             | ({DATA_WIDTH{dsel_r[i]}} & bus.hrdata_s[i*DATA_WIDTH +: DATA_WIDTH]);
            end
        end else begin
            hready_mux_s = 1'b1;
            hresp_mux_s  = 1'b0;
        end
    end

    assign bus.hrdata = hrdata_mux_s;
    assign bus.hready = hready_mux_s;
    assign bus.hresp  = hresp_mux_s;

`ifdef ML_AHB_ERR_CAPTURE_EN
    logic [31:0] err_addr_r;
    logic        err_valid_r;

    // First-error capture; a new capture takes priority over a simultaneous clear.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            err_addr_r  <= 32'h0000_0000;
            err_valid_r <= 1'b0;
        end else if (accept_s && def_req_s && (!err_valid_r || bus.err_clr)) begin
            err_addr_r  <= bus.haddr;
            err_valid_r <= 1'b1;
        end else if (bus.err_clr) begin
            err_addr_r  <= err_addr_r;
            err_valid_r <= 1'b0;
        end else begin
            err_addr_r  <= err_addr_r;
            err_valid_r <= err_valid_r;
        end
    end

    assign bus.err_addr  = err_addr_r;
    assign bus.err_valid = err_valid_r;
`else
    logic unused_haddr_s;
    assign unused_haddr_s = ^bus.haddr;
`endif

endmodule
